// File: rtl/frame_config_sequencer.sv
// Word-stream frame configuration sequencer: sync detect, frame assembly, one-hot column strobes.
// Optional CONFIG_CRC_EN adds a CHECK state that verifies an XOR word before committing a frame.
module frame_config_sequencer #(
  parameter int NumberOfRows     = 10,
  parameter int NumberOfCols     = 10,
  parameter int FrameBitsPerRow  = 32,
  parameter int MaxFramesPerCol  = 20,
  parameter int desync_flag      = 20,
  parameter int FrameSelectWidth = 5,
  parameter logic [FrameBitsPerRow-1:0] SyncWord = 32'hFAB0_FAB1
) (
  input  logic                                             CLK,
  input  logic                                             resetn,
  input  logic [FrameBitsPerRow-1:0]                       cfg_data,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  output logic [FrameBitsPerRow*(NumberOfRows+2)-1:0]      FrameData,
  output logic [MaxFramesPerCol*NumberOfCols-1:0]          FrameStrobe,
  output logic                                             ComActive,
  output logic                                             cfg_error,
  output logic [15:0]                                      frame_count
);

  localparam int Words = NumberOfRows + 2;
  localparam int CntW  = $clog2(Words);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
`ifdef CONFIG_CRC_EN
    CHECK,
`endif
    STROBE
  } state_t;

  state_t state_q, state_d;

  logic [MaxFramesPerCol-1:0]                 frame_bits;
  logic [FrameSelectWidth-1:0]                col;
  logic [CntW-1:0]                            word_cnt;
  logic [CntW-1:0]                            row_idx;
  logic [MaxFramesPerCol*NumberOfCols-1:0]    strobe_vec;
  logic                                       accept;
  logic                                       last_word;
  logic                                       enter_strobe;
  logic                                       err_set;
`ifdef CONFIG_CRC_EN
  logic [FrameBitsPerRow-1:0]                 crc;
`endif

  // Broadcast (all-ones) is the only legal out-of-range column code.
  function automatic logic col_ok(input logic [FrameSelectWidth-1:0] c);
    return (c == '1) || (32'(c) < 32'(NumberOfCols));
  endfunction

  assign accept       = cfg_valid & cfg_ready;
  assign last_word    = (word_cnt == CntW'(Words - 1));
  assign row_idx      = CntW'(Words - 1) - word_cnt;
  assign enter_strobe = (state_d == STROBE) && (state_q != STROBE);

  always_comb begin
    strobe_vec = '0;
    for (int c = 0; c < NumberOfCols; c++) begin
      if ((col == '1) || (32'(col) == 32'(c)))
        strobe_vec[c*MaxFramesPerCol +: MaxFramesPerCol] = frame_bits;
    end
  end

  always_comb begin
    err_set = 1'b0;
`ifdef CONFIG_CRC_EN
    if (accept && (state_q == CHECK) && !((cfg_data == (crc ^ '0)) && col_ok(col)))
      err_set = 1'b1;
`else
    if (accept && (state_q == DATA) && last_word && !col_ok(col))
      err_set = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept && (cfg_data == SyncWord)) state_d = ADDR;
      ADDR:   if (accept) state_d = cfg_data[desync_flag] ? IDLE : DATA;
`ifdef CONFIG_CRC_EN
      DATA:   if (accept && last_word) state_d = CHECK;
      CHECK:  if (accept) state_d = ((cfg_data == crc) && col_ok(col)) ? STROBE : ADDR;
`else
      DATA:   if (accept && last_word) state_d = col_ok(col) ? STROBE : ADDR;
`endif
      STROBE: state_d = ADDR;
      default: state_d = IDLE;
    endcase
  end

  // Ready is forced low while reset is held so no word is taken during reset.
  always_comb begin
    cfg_ready = resetn && (state_q != STROBE);
    ComActive = (state_q != IDLE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_error   <= 1'b0;
      frame_count <= '0;
      frame_bits  <= '0;
      col         <= '0;
      word_cnt    <= '0;
`ifdef CONFIG_CRC_EN
      crc         <= '0;
`endif
    end else begin
      FrameStrobe <= enter_strobe ? strobe_vec : '0;
      if (enter_strobe) frame_count <= frame_count + 16'd1;
      if (err_set) cfg_error <= 1'b1;
      if (accept && (state_q == IDLE) && (cfg_data == SyncWord)) cfg_error <= 1'b0;
      if (accept && (state_q == ADDR) && !cfg_data[desync_flag]) begin
        frame_bits <= cfg_data[MaxFramesPerCol-1:0];
        col        <= cfg_data[FrameBitsPerRow-1 -: FrameSelectWidth];
        word_cnt   <= '0;
`ifdef CONFIG_CRC_EN
        crc        <= cfg_data;
`endif
      end
      // Words arrive top row first.
      if (accept && (state_q == DATA)) begin
        FrameData[row_idx*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
        word_cnt <= word_cnt + CntW'(1);
`ifdef CONFIG_CRC_EN
        crc      <= crc ^ cfg_data;
`endif
      end
    end
  end

endmodule
